// File: rtl/cop0_register_file.sv
// Coprocessor-0 register file: MTC0/MFC0 access, Count/Compare timer,
// interrupt request generation and exception/ERET state tracking.
module cop0_register_file #(
  parameter logic [31:0] PRID      = 32'h0001_8000,
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [2:0]  wsel,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  input  logic [2:0]  rsel,
  output logic [31:0] rdata,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic        exc_badvaddr_valid,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret,
  input  logic [5:0]  hw_int,
  output logic        int_pending,
  output logic [31:0] epc_out,
  output logic        exl_out
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [3:0] DIV_LAST     = 4'(COUNT_DIV - 1);

  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] epc_q, epc_d;
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic        ti_q, ti_d;
  logic [5:0]  ip_hw_q;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  code_q, code_d;
  logic [3:0]  div_q, div_d;
  logic        count_upd;

  logic wr_sel0, wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic [7:0] cause_ip;

  assign wr_sel0    = we && (wsel == 3'd0);
  assign wr_count   = wr_sel0 && (waddr == REG_COUNT);
  assign wr_compare = wr_sel0 && (waddr == REG_COMPARE);
  assign wr_status  = wr_sel0 && (waddr == REG_STATUS);
  assign wr_cause   = wr_sel0 && (waddr == REG_CAUSE);
  assign wr_epc     = wr_sel0 && (waddr == REG_EPC);

  // IP7 is shared between hardware line 5 and the timer.
  assign cause_ip = {ip_hw_q[5] | ti_q, ip_hw_q[4:0], ip_sw_q};

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    div_d     = div_q;
    count_d   = count_q;
    count_upd = 1'b0;
    if (wr_count) begin
      count_d   = wdata;
      div_d     = 4'd0;
      count_upd = 1'b1;
    end else if (div_q == DIV_LAST) begin
      count_d   = count_q + 32'd1;
      div_d     = 4'd0;
      count_upd = 1'b1;
    end else begin
      div_d = div_q + 4'd1;
    end

    compare_d = wr_compare ? wdata : compare_q;
    ti_d      = ti_q;
    if (wr_compare)                            ti_d = 1'b0;
    else if (count_upd && count_d == compare_q) ti_d = 1'b1;

    badvaddr_d = badvaddr_q;
    epc_d      = epc_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    code_d     = code_q;

    if (exc_valid) begin
      code_d = exc_code;
      if (!exl_q) begin
        epc_d = exc_bd ? exc_pc - 32'd4 : exc_pc;
        bd_d  = exc_bd;
      end
      exl_d = 1'b1;
      if (exc_badvaddr_valid) badvaddr_d = exc_badvaddr;
    end else begin
      if (wr_status) begin
        im_d  = wdata[15:8];
        exl_d = wdata[1];
        ie_d  = wdata[0];
      end
      // ERET wins over the EXL bit of a simultaneous Status write.
      if (eret)     exl_d   = 1'b0;
      if (wr_cause) ip_sw_d = wdata[9:8];
      if (wr_epc)   epc_d   = wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      badvaddr_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      epc_q      <= '0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      ip_hw_q    <= '0;
      ip_sw_q    <= '0;
      code_q     <= '0;
      div_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge state.
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      epc_q      <= epc_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      ip_hw_q    <= hw_int;
      ip_sw_q    <= ip_sw_d;
      code_q     <= code_d;
      div_q      <= div_d;
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (rsel == 3'd0) begin
      case (raddr)
        REG_BADVADDR: rdata = badvaddr_q;
        REG_COUNT:    rdata = count_q;
        REG_COMPARE:  rdata = compare_q;
        REG_STATUS:   rdata = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
        REG_CAUSE:    rdata = {bd_q, ti_q, 14'd0, cause_ip, 1'b0, code_q, 2'd0};
        REG_EPC:      rdata = epc_q;
        REG_PRID:     rdata = PRID;
        default:      rdata = 32'd0;
      endcase
    end
  end

  assign int_pending = ie_q & ~exl_q & (|(cause_ip & im_q));
  assign epc_out     = epc_q;
  assign exl_out     = exl_q;

endmodule

// File: tb/tb_cop0_register_file.sv
// Directed bench for cop0_register_file: register map, timer interrupt,
// exception/ERET priority, Count wrap and asynchronous reset.
`timescale 1ns/1ps
module tb_cop0_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  waddr;
  logic [2:0]  wsel;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [2:0]  rsel;
  logic [31:0] rdata;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        exc_badvaddr_valid;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic [5:0]  hw_int;
  logic        int_pending;
  logic [31:0] epc_out;
  logic        exl_out;

  int checks   = 0;
  int failures = 0;

  cop0_register_file #(.PRID(32'h0001_8000), .COUNT_DIV(2)) dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wsel(wsel), .wdata(wdata),
    .raddr(raddr), .rsel(rsel), .rdata(rdata),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_badvaddr_valid(exc_badvaddr_valid), .exc_badvaddr(exc_badvaddr),
    .eret(eret), .hw_int(hw_int), .int_pending(int_pending),
    .epc_out(epc_out), .exl_out(exl_out)
  );

  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [4:0] a, input logic [2:0] s,
                        input logic [31:0] exp);
    raddr = a;
    rsel  = s;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
    waddr = a;
    wsel  = s;
    wdata = d;
    we    = 1'b1;
    step();
    we    = 1'b0;
  endtask

  task automatic raise_exc(input logic [31:0] pc, input logic bd, input logic [4:0] code,
                           input logic bav, input logic [31:0] addr);
    exc_valid          = 1'b1;
    exc_pc             = pc;
    exc_bd             = bd;
    exc_code           = code;
    exc_badvaddr_valid = bav;
    exc_badvaddr       = addr;
  endtask

  task automatic clear_ctl();
    exc_valid          = 1'b0;
    exc_badvaddr_valid = 1'b0;
    eret               = 1'b0;
    we                 = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    we = 1'b0; waddr = '0; wsel = '0; wdata = '0; raddr = '0; rsel = '0;
    exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_bd = 1'b0;
    exc_badvaddr_valid = 1'b0; exc_badvaddr = '0; eret = 1'b0; hw_int = '0;
    repeat (2) step();
    reset = 1'b0;

    chk_rd("rst_status", 5'd12, 3'd0, 32'h0040_0000);
    chk_rd("rst_prid",   5'd15, 3'd0, 32'h0001_8000);
    chk_rd("rst_cause",  5'd13, 3'd0, 32'h0000_0000);
    check("rst_int", {31'd0, int_pending}, 32'd0);
    check("rst_epc", epc_out, 32'd0);
    check("rst_exl", {31'd0, exl_out}, 32'd0);

    mtc0(5'd12, 3'd0, 32'hFFFF_FFFF);
    chk_rd("status_mask", 5'd12, 3'd0, 32'h0040_FF03);

    // Timer: Count=10, Compare=13, divider 2 -> match six edges after the Count write.
    mtc0(5'd12, 3'd0, 32'h0000_8001);
    mtc0(5'd11, 3'd0, 32'd13);
    mtc0(5'd9,  3'd0, 32'd10);
    chk_rd("count_load", 5'd9, 3'd0, 32'd10);
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 5) check("ti_early", {31'd0, int_pending}, 32'd0);
    end
    check("ti_int", {31'd0, int_pending}, 32'd1);
    chk_rd("ti_cause", 5'd13, 3'd0, 32'h4000_8000);
    chk_rd("ti_count", 5'd9,  3'd0, 32'd13);
    mtc0(5'd11, 3'd0, 32'd100);
    chk_rd("ti_clear", 5'd13, 3'd0, 32'h0000_0000);
    check("ti_int_clr", {31'd0, int_pending}, 32'd0);

    // First exception, in a delay slot.
    raise_exc(32'h8000_0104, 1'b1, 5'h04, 1'b1, 32'h1234_5671);
    step();
    clear_ctl();
    chk_rd("exc1_epc",   5'd14, 3'd0, 32'h8000_0100);
    check("exc1_epc_out", epc_out, 32'h8000_0100);
    check("exc1_exl", {31'd0, exl_out}, 32'd1);
    chk_rd("exc1_cause", 5'd13, 3'd0, 32'h8000_0010);
    chk_rd("exc1_bva",   5'd8,  3'd0, 32'h1234_5671);
    chk_rd("exc1_stat",  5'd12, 3'd0, 32'h0040_8003);
    check("exc1_int", {31'd0, int_pending}, 32'd0);

    // Nested exception while EXL=1: EPC/BD/BadVAddr hold, ExcCode updates.
    raise_exc(32'h0000_2000, 1'b0, 5'h0C, 1'b0, 32'hFFFF_0000);
    step();
    clear_ctl();
    chk_rd("exc2_epc",   5'd14, 3'd0, 32'h8000_0100);
    chk_rd("exc2_cause", 5'd13, 3'd0, 32'h8000_0030);
    chk_rd("exc2_bva",   5'd8,  3'd0, 32'h1234_5671);

    eret = 1'b1;
    step();
    clear_ctl();
    check("eret1_exl", {31'd0, exl_out}, 32'd0);
    chk_rd("eret1_stat", 5'd12, 3'd0, 32'h0040_8001);

    // Exception beats a same-cycle EPC write.
    raise_exc(32'h0000_3000, 1'b0, 5'h08, 1'b0, 32'h0);
    waddr = 5'd14; wsel = 3'd0; wdata = 32'hDEAD_BEEF; we = 1'b1;
    step();
    clear_ctl();
    chk_rd("excwe_epc",   5'd14, 3'd0, 32'h0000_3000);
    chk_rd("excwe_cause", 5'd13, 3'd0, 32'h0000_0020);

    // ERET beats Status.EXL of a same-cycle Status write; other bits still land.
    eret = 1'b1;
    waddr = 5'd12; wsel = 3'd0; wdata = 32'hFFFF_FFFF; we = 1'b1;
    step();
    clear_ctl();
    check("eretwe_exl", {31'd0, exl_out}, 32'd0);
    chk_rd("eretwe_stat", 5'd12, 3'd0, 32'h0040_FF01);

    // Exception with a same-cycle Compare write: the Compare write commits.
    raise_exc(32'h0000_4000, 1'b0, 5'h0A, 1'b0, 32'h0);
    waddr = 5'd11; wsel = 3'd0; wdata = 32'd500; we = 1'b1;
    step();
    clear_ctl();
    chk_rd("exccmp_cmp", 5'd11, 3'd0, 32'd500);
    check("exccmp_epc", epc_out, 32'h0000_4000);
    eret = 1'b1;
    step();
    clear_ctl();

    // Hardware and software interrupt lines.
    hw_int = 6'b000001;
    step();
    chk_rd("hw_cause", 5'd13, 3'd0, 32'h0000_0428);
    check("hw_int", {31'd0, int_pending}, 32'd1);
    mtc0(5'd13, 3'd0, 32'hFFFF_FFFF);
    chk_rd("sw_cause", 5'd13, 3'd0, 32'h0000_0728);
    hw_int = 6'b000000;
    mtc0(5'd13, 3'd0, 32'h0000_0000);
    chk_rd("ip_clear", 5'd13, 3'd0, 32'h0000_0028);
    check("ip_int", {31'd0, int_pending}, 32'd0);

    // Unmapped / read-only locations.
    chk_rd("unmapped_rd", 5'd3,  3'd0, 32'd0);
    chk_rd("sel1_rd",     5'd12, 3'd1, 32'd0);
    mtc0(5'd12, 3'd1, 32'h0000_0000);
    chk_rd("sel1_wr",     5'd12, 3'd0, 32'h0040_FF01);
    mtc0(5'd15, 3'd0, 32'h0000_0000);
    chk_rd("prid_ro",     5'd15, 3'd0, 32'h0001_8000);
    mtc0(5'd8,  3'd0, 32'h0000_0000);
    chk_rd("bva_ro",      5'd8,  3'd0, 32'h1234_5671);

    // Count wrap.
    mtc0(5'd9, 3'd0, 32'hFFFF_FFFF);
    chk_rd("wrap_load", 5'd9, 3'd0, 32'hFFFF_FFFF);
    step();
    chk_rd("wrap_hold", 5'd9, 3'd0, 32'hFFFF_FFFF);
    step();
    chk_rd("wrap_zero", 5'd9, 3'd0, 32'h0000_0000);
    repeat (4) step();
    chk_rd("wrap_two",  5'd9, 3'd0, 32'd2);

    // Asynchronous reset between clock edges.
    #10;
    reset = 1'b1;
    chk_rd("areset_count",  5'd9,  3'd0, 32'd0);
    chk_rd("areset_status", 5'd12, 3'd0, 32'h0040_0000);
    chk_rd("areset_cmp",    5'd11, 3'd0, 32'd0);
    check("areset_epc", epc_out, 32'd0);
    check("areset_exl", {31'd0, exl_out}, 32'd0);
    check("areset_int", {31'd0, int_pending}, 32'd0);
    step();
    reset = 1'b0;
    // Divider restarted from 0: first increment needs two edges.
    step();
    chk_rd("areset_div1", 5'd9, 3'd0, 32'd0);
    step();
    chk_rd("areset_div2", 5'd9, 3'd0, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cop0_register_file.md
Name: cop0_register_file

Overview:
- Coprocessor-0 register file that executes the control words produced for MTC0/MFC0, and records exception and ERET state.
- Sits at the writeback boundary of the pipeline. Serves MFC0 reads combinationally and commits MTC0 writes on the clock edge.
- Also runs the Count/Compare timer and produces the interrupt request consumed by the exception unit.

Parameters:
- PRID, 32'h0001_8000, read-only value of PRId (reg 15, sel 0).
- COUNT_DIV, 2, clock cycles per Count increment. Legal range 1..16.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- we  in  1  MTC0 commit strobe (write_cop0 from the decoded control word)
- waddr  in  5  MTC0 destination register (rd field)
- wsel  in  3  MTC0 select field
- wdata  in  32  MTC0 data (rt operand)
- raddr  in  5  MFC0 source register
- rsel  in  3  MFC0 select field
- rdata  out  32  MFC0 read data, combinational
- exc_valid  in  1  exception commit this cycle
- exc_code  in  5  Cause.ExcCode value
- exc_pc  in  32  PC of faulting instruction
- exc_bd  in  1  faulting instruction is in a delay slot
- exc_badvaddr_valid  in  1  load BadVAddr on this exception
- exc_badvaddr  in  32  faulting address
- eret  in  1  ERET commit
- hw_int  in  6  hardware interrupt lines, level sensitive
- int_pending  out  1  interrupt request to exception unit
- epc_out  out  32  current EPC (ERET target)
- exl_out  out  1  current Status.EXL

Behaviour:

Register map (sel 0 only):
- 8 BadVAddr: read-only.
- 9 Count: read/write.
- 11 Compare: read/write.
- 12 Status: IM[15:8], EXL[1], IE[0] writable; BEV[22] reads 1; all other bits read 0.
- 13 Cause: BD[31] RO, TI[30] RO, IP[15:10] RO, IP[9:8] writable, ExcCode[6:2] RO; all other bits 0.
- 14 EPC: read/write.
- 15 PRId: read-only, returns PRID.
- Any other reg/sel: rdata = 0, and writes are ignored.

Reset values:
- All registers 0, except Status = 32'h0040_0000 and PRId = PRID.
- Internal divider = 0.
- Outputs: int_pending 0, epc_out 0, exl_out 0.

Reads:
- rdata reflects register state before this cycle's edge. There is no write-to-read bypass; the pipeline handles that hazard.

Count:
- Divider counts 0..COUNT_DIV-1. Count increments by 1 (mod 2^32) when the divider wraps.
- An MTC0 to Count loads wdata, resets the divider, and overrides that cycle's increment.

Timer interrupt:
- TI is set on the edge where the updated Count equals Compare.
- An MTC0 to Compare loads Compare and clears TI in the same edge. This takes priority over a simultaneous match.

Interrupt lines:
- Cause.IP[15:10] is registered from hw_int every cycle.
- IP[15] = hw_int[5] | TI.

Interrupt request:
- int_pending = Status.IE & ~Status.EXL & |(Cause.IP[15:8] & Status.IM).
- Computed combinationally from registered state.

Exception commit (exc_valid):
- ExcCode is set to exc_code.
- If EXL = 0: EPC is set to exc_bd ? exc_pc-4 : exc_pc, and BD is set to exc_bd.
- If EXL = 1: EPC and BD are unchanged.
- EXL is set to 1.
- If exc_badvaddr_valid: BadVAddr is set to exc_badvaddr.

ERET:
- EXL is cleared to 0.

Same-cycle priority:
- exc_valid beats eret, and beats a we to Status/Cause/EPC.
- A simultaneous we to other registers (Count, Compare) still commits.
- eret beats a simultaneous we to Status EXL. The other writable Status bits still take wdata.

Reset mid-operation:
- Asserting reset returns everything to reset values immediately, independent of clk. This includes a partially elapsed divider.

Test Plan:
- Reset then MFC0 12/15 -> rdata 32'h0040_0000, then 32'h0001_8000; int_pending 0.
- MTC0 Status=32'hFFFF_FFFF -> read 32'h0040_FF03 (writable bits plus BEV).
- MTC0 Count=10, Compare=13, COUNT_DIV=2 -> TI and int_pending rise 6 cycles later, with Status IE=1 and IM7=1 set beforehand. A subsequent MTC0 Compare clears TI on the next edge.
- exc_valid with exc_pc=32'h8000_0104, exc_bd=1, code 5'h04, badvaddr 32'h1234_5671 -> EPC 32'h8000_0100, BD=1, ExcCode 4, EXL 1, BadVAddr 32'h1234_5671. A second exception while EXL=1 leaves EPC unchanged.
- Same cycle: exc_valid plus we to EPC with 32'hDEAD_BEEF -> EPC takes the exception value. Then eret -> exl_out 0.
- Count at 32'hFFFF_FFFF plus one increment -> 0. Reset asserted mid-count -> Count 0 asynchronously.
